// File: rtl/popcount_seq_ctrl_if.sv
// Producer/consumer handshake bundle for popcount_seq_ctrl.
// The DUT takes the slave side and the environment takes the master side.
interface popcount_seq_ctrl_if #(
    parameter int DATA_W = 16
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic              busy;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_count,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_count,
        output busy
    );
endinterface

// File: rtl/popcount_seq_ctrl.sv
// Nibble-serial popcount sequencer built around one 4-bit count_1 datapath.
// Define POPCNT_EARLY_EXIT_EN to finish as soon as no 1 bits remain.
module count_1 (
    input  logic [3:0] nib_i,
    output logic [2:0] cnt_o
);
    assign cnt_o = {2'b00, nib_i[0]} + {2'b00, nib_i[1]}
                 + {2'b00, nib_i[2]} + {2'b00, nib_i[3]};
endmodule

module popcount_seq_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    popcount_seq_ctrl_if.slave  bus
);
    localparam int NIB   = DATA_W / 4;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    if ((DATA_W % 4) != 0 || DATA_W < 4) begin : g_bad_width
        $error("popcount_seq_ctrl: DATA_W must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [2:0]        part;

    count_1 u_count_1 (
        .nib_i (shreg_q[3:0]),
        .cnt_o (part)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        shreg_d       = shreg_q;
        idx_d         = idx_q;
        bus.in_ready  = (state_q == IDLE) && !rst;
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q != IDLE);
        bus.out_count = (state_q == DONE) ? acc_q : '0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    shreg_d = bus.in_data;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
`ifdef POPCNT_EARLY_EXIT_EN
                    if (bus.in_data == '0)
                        state_d = DONE;
`endif
                end
            end
            RUN: begin
                acc_d   = acc_q + CNT_W'(part);
                shreg_d = shreg_q >> 4;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NIB - 1))
                    state_d = DONE;
`ifdef POPCNT_EARLY_EXIT_EN
                // Nothing left above this nibble: the sum is final.
                if ((shreg_q >> 4) == '0)
                    state_d = DONE;
`endif
            end
            DONE: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule
